// File: rtl/mux2_rr_arbiter.sv
// Two-requester packet arbiter driving a 2:1 mux onto one downstream channel.
// Latency: one cycle from valid to grant, then zero-latency combinational data path.
// Backpressure: out_ready reaches only the granted requester; the grant holds until its last beat.
module mux2_rr_arbiter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic              b_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy,
   output logic [CNT_W-1:0]  a_pkt_cnt,
   output logic [CNT_W-1:0]  b_pkt_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t state;
   logic   prio;          // 0: A wins a tie, 1: B wins a tie
   logic   a_done;
   logic   b_done;

   assign a_done = (state == GNT_A) && a_valid && out_ready && a_last;
   assign b_done = (state == GNT_B) && b_valid && out_ready && b_last;

   // Handshake signals decode straight from the registered state so reset clears them without a clock.
   assign out_valid = ((state == GNT_A) && a_valid) || ((state == GNT_B) && b_valid);
   assign a_ready   = (state == GNT_A) && out_ready;
   assign b_ready   = (state == GNT_B) && out_ready;
   assign out_data  = sel ? b_data : a_data;
   assign out_last  = sel ? b_last : a_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 1'b0;
         prio      <= 1'b0;
         busy      <= 1'b0;
         a_pkt_cnt <= '0;
         b_pkt_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a_valid && (!b_valid || !prio)) begin
                  state <= GNT_A;
                  sel   <= 1'b0;
                  busy  <= 1'b1;
               end else if (b_valid) begin
                  state <= GNT_B;
                  sel   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            GNT_A: begin
               if (a_done) begin
                  a_pkt_cnt <= a_pkt_cnt + CNT_W'(1);
                  prio      <= 1'b1;
                  if (b_valid) begin
                     state <= GNT_B;
                     sel   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            GNT_B: begin
               if (b_done) begin
                  b_pkt_cnt <= b_pkt_cnt + CNT_W'(1);
                  prio      <= 1'b0;
                  if (a_valid) begin
                     state <= GNT_A;
                     sel   <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
